// File: rtl/rx_block_sync_descrambler.sv
// rx_block_sync_descrambler: 64b/66b block-lock state machine driving gearbox slips, plus a
// self-synchronous x^58 + x^39 + 1 descrambler for the payload (two 32-bit words per block).
module rx_block_sync_descrambler #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned HDR_WIDTH    = 2,
    parameter int unsigned SH_CNT_MAX   = 64,
    parameter int unsigned SH_INVLD_MAX = 16,
    parameter int unsigned SLIP_WAIT    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                 i_rx_data_valid,
    input  logic [HDR_WIDTH-1:0] i_rx_hdr,
    input  logic                 i_rx_hdr_valid,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                 o_rx_data_valid,
    output logic [HDR_WIDTH-1:0] o_rx_hdr,
    output logic                 o_rx_hdr_valid,
    output logic                 o_block_lock,
    output logic                 o_gearbox_slip
);

    localparam int unsigned ScrW   = 58;
    localparam int unsigned ShCntW = 7;
    localparam int unsigned InvldW = 5;
    localparam int unsigned WaitW  = $clog2(SLIP_WAIT + 1);

    localparam logic [ShCntW-1:0] ShCntMax = ShCntW'(SH_CNT_MAX);
    localparam logic [InvldW-1:0] InvldMax = InvldW'(SH_INVLD_MAX);
    localparam logic [WaitW-1:0]  WaitLoad = WaitW'(SLIP_WAIT);

    typedef enum logic [1:0] {
        StLockInit,
        StTestSh,
        StSlip,
        StSlipWait
    } state_e;

    state_e               r_state, w_state_d;
    logic [ShCntW-1:0]    r_sh_cnt, w_sh_cnt_d, w_sh_cnt_inc;
    logic [InvldW-1:0]    r_invld_cnt, w_invld_cnt_d, w_invld_cnt_inc;
    logic [WaitW-1:0]     r_wait_cnt, w_wait_cnt_d;
    logic                 r_block_lock, w_block_lock_d;
    logic                 r_slip, w_slip_d;

    logic [ScrW-1:0]       r_scr_state, w_scr_state_d;
    logic [DATA_WIDTH-1:0] w_descr;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_data_valid;
    logic [HDR_WIDTH-1:0]  r_rx_hdr;
    logic                  r_rx_hdr_valid;

    logic w_hdr_event;
    logic w_hdr_ok;

    assign w_hdr_event = i_rx_hdr_valid & i_rx_data_valid;
    assign w_hdr_ok    = (i_rx_hdr == HDR_WIDTH'(1)) || (i_rx_hdr == HDR_WIDTH'(2));

    // Bit-serial descrambler unrolled over the word, LSB first; received bits feed the state.
    always_comb begin
        w_scr_state_d = r_scr_state;
        w_descr       = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_descr[i]    = i_rx_data[i] ^ w_scr_state_d[38] ^ w_scr_state_d[57];
            w_scr_state_d = {w_scr_state_d[ScrW-2:0], i_rx_data[i]};
        end
    end

    // Datapath registers: descrambler state and the one-cycle-latency output stage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_scr_state     <= '0;
            r_rx_data       <= '0;
            r_rx_data_valid <= 1'b0;
            r_rx_hdr        <= '0;
            r_rx_hdr_valid  <= 1'b0;
        end else begin
            r_rx_data_valid <= i_rx_data_valid;
            r_rx_hdr_valid  <= w_hdr_event;
            if (i_rx_data_valid) begin
                r_scr_state <= w_scr_state_d;
                r_rx_data   <= w_descr;
            end
            if (w_hdr_event) begin
                r_rx_hdr <= i_rx_hdr;
            end
        end
    end

    // Block-lock next state; slip and lock are decided here and registered with the state.
    always_comb begin
        w_state_d       = r_state;
        w_sh_cnt_d      = r_sh_cnt;
        w_invld_cnt_d   = r_invld_cnt;
        w_wait_cnt_d    = r_wait_cnt;
        w_block_lock_d  = r_block_lock;
        w_slip_d        = 1'b0;
        w_sh_cnt_inc    = r_sh_cnt + 1'b1;
        w_invld_cnt_inc = r_invld_cnt + InvldW'(!w_hdr_ok);

        unique case (r_state)
            StLockInit: begin
                w_sh_cnt_d    = '0;
                w_invld_cnt_d = '0;
                w_state_d     = StTestSh;
            end
            StTestSh: begin
                if (w_hdr_event) begin
                    w_sh_cnt_d    = w_sh_cnt_inc;
                    w_invld_cnt_d = w_invld_cnt_inc;
                    if (!r_block_lock && !w_hdr_ok) begin
                        w_state_d = StSlip;
                        w_slip_d  = 1'b1;
                    end else if (r_block_lock && (w_invld_cnt_inc == InvldMax)) begin
                        // Threshold wins over a coincident window end.
                        w_block_lock_d = 1'b0;
                        w_state_d      = StSlip;
                        w_slip_d       = 1'b1;
                    end else if (w_sh_cnt_inc == ShCntMax) begin
                        if (w_invld_cnt_inc == '0) begin
                            w_block_lock_d = 1'b1;
                        end
                        w_sh_cnt_d    = '0;
                        w_invld_cnt_d = '0;
                    end
                end
            end
            StSlip: begin
                w_sh_cnt_d    = '0;
                w_invld_cnt_d = '0;
                w_wait_cnt_d  = WaitLoad;
                w_state_d     = StSlipWait;
            end
            StSlipWait: begin
                if (r_wait_cnt == '0) begin
                    w_state_d = StTestSh;
                end else if (w_hdr_event) begin
                    w_wait_cnt_d = r_wait_cnt - 1'b1;
                    if (r_wait_cnt == WaitW'(1)) begin
                        w_state_d = StTestSh;
                    end
                end
            end
            default: w_state_d = StLockInit;
        endcase
    end

    // Block-lock state register; reset drops lock at once and never issues a slip.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StLockInit;
            r_sh_cnt     <= '0;
            r_invld_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_block_lock <= 1'b0;
            r_slip       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_sh_cnt     <= w_sh_cnt_d;
            r_invld_cnt  <= w_invld_cnt_d;
            r_wait_cnt   <= w_wait_cnt_d;
            r_block_lock <= w_block_lock_d;
            r_slip       <= w_slip_d;
        end
    end

    assign o_rx_data       = r_rx_data;
    assign o_rx_data_valid = r_rx_data_valid;
    assign o_rx_hdr        = r_rx_hdr;
    assign o_rx_hdr_valid  = r_rx_hdr_valid;
    assign o_block_lock    = r_block_lock;
    assign o_gearbox_slip  = r_slip;

endmodule

// File: tb/tb_rx_block_sync_descrambler.sv
// Bench for rx_block_sync_descrambler: a reference scrambler feeds the DUT, plaintext is queued
// as the expected output and popped when the DUT presents a valid word.
module tb_rx_block_sync_descrambler;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [31:0] i_rx_data = '0;
    logic        i_rx_data_valid = 1'b0;
    logic [1:0]  i_rx_hdr = '0;
    logic        i_rx_hdr_valid = 1'b0;
    logic [31:0] o_rx_data;
    logic        o_rx_data_valid;
    logic [1:0]  o_rx_hdr;
    logic        o_rx_hdr_valid;
    logic        o_block_lock;
    logic        o_gearbox_slip;

    always #5 i_clk = ~i_clk;

    rx_block_sync_descrambler dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_rx_data       (i_rx_data),
        .i_rx_data_valid (i_rx_data_valid),
        .i_rx_hdr        (i_rx_hdr),
        .i_rx_hdr_valid  (i_rx_hdr_valid),
        .o_rx_data       (o_rx_data),
        .o_rx_data_valid (o_rx_data_valid),
        .o_rx_hdr        (o_rx_hdr),
        .o_rx_hdr_valid  (o_rx_hdr_valid),
        .o_block_lock    (o_block_lock),
        .o_gearbox_slip  (o_gearbox_slip)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  hdr;
        logic        hev;
        logic        chk;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          slip_cnt = 0;
    int          words_since_rst = 0;
    logic        prev_slip = 1'b0;
    logic [57:0] sc = '0;
    logic [57:0] seed4 = '0;
    logic        lock_at_hdr, slip_at_hdr;
    logic [31:0] out_w0, out_w1;
    logic [31:0] t4_out[16];

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Scrambler reference: the transmitted bit feeds back into the state.
    task automatic put_word(input logic [31:0] pl, input logic dv, input logic hv,
                            input logic [1:0] hdr);
        logic [31:0] s;
        sb_t e;
        s = pl;
        if (dv) begin
            for (int i = 0; i < 32; i++) begin
                s[i] = pl[i] ^ sc[38] ^ sc[57];
                sc   = {sc[56:0], s[i]};
            end
            e.data = pl;
            e.hdr  = hdr;
            e.hev  = hv;
            e.chk  = (words_since_rst >= 2);
            sb_q.push_back(e);
            words_since_rst++;
        end
        i_rx_data       = s;
        i_rx_data_valid = dv;
        i_rx_hdr_valid  = hv;
        i_rx_hdr        = hdr;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_rx_data_valid = 1'b0;
        i_rx_hdr_valid  = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_block(input logic [1:0] hdr, input logic [63:0] pl);
        put_word(pl[31:0], 1'b1, 1'b1, hdr);
        lock_at_hdr = o_block_lock;
        slip_at_hdr = o_gearbox_slip;
        out_w0      = o_rx_data;
        put_word(pl[63:32], 1'b1, 1'b0, hdr);
        out_w1 = o_rx_data;
    endtask

    // Scoreboard pop and slip-pulse monitor, sampled away from the active edge.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_gearbox_slip) begin
                slip_cnt++;
                n_checks++;
                if (prev_slip !== 1'b0) $display("FAIL slip_consecutive: got 2 cycles want 1");
                else n_pass++;
            end
            prev_slip = o_gearbox_slip;
            if (o_rx_data_valid) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got valid word %h want none", o_rx_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ((o_rx_hdr_valid !== mon_e.hev) ||
                        (mon_e.hev && (o_rx_hdr !== mon_e.hdr)) ||
                        (mon_e.chk && (o_rx_data !== mon_e.data)))
                        $display("FAIL sb_word: got d=%h h=%b hv=%b want d=%h h=%b hv=%b",
                                 o_rx_data, o_rx_hdr, o_rx_hdr_valid,
                                 mon_e.data, mon_e.hdr, mon_e.hev);
                    else n_pass++;
                end
            end else if (o_rx_hdr_valid) begin
                n_checks++;
                $display("FAIL hdr_valid_alone: got hdr_valid=1 want 0");
            end
        end else begin
            prev_slip = 1'b0;
        end
    end

    task automatic test_reset();
        idle(1);
        n_checks++;
        if (sb_q.size() !== 0) $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        else n_pass++;
        i_reset_n = 1'b0;
        idle(3);
        n_checks++;
        if ({o_rx_data, o_rx_data_valid, o_rx_hdr, o_rx_hdr_valid, o_block_lock,
             o_gearbox_slip} !== 38'h0)
            $display("FAIL reset_outputs: got %h_%b_%b_%b_%b_%b want all 0", o_rx_data,
                     o_rx_data_valid, o_rx_hdr, o_rx_hdr_valid, o_block_lock, o_gearbox_slip);
        else n_pass++;
        words_since_rst = 0;
        i_reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_lock_acquire();
        int s0;
        test_reset();
        s0 = slip_cnt;
        for (int b = 0; b < 64; b++) begin
            send_block((b % 2 == 1) ? 2'b10 : 2'b01, rnd64());
            if (b == 62) begin
                n_checks++;
                if (lock_at_hdr !== 1'b0) $display("FAIL acq_early: got lock=%b want 0", lock_at_hdr);
                else n_pass++;
            end
        end
        n_checks++;
        if (lock_at_hdr !== 1'b1) $display("FAIL acq_lock: got lock=%b want 1", lock_at_hdr);
        else n_pass++;
        n_checks++;
        if (slip_cnt - s0 !== 0) $display("FAIL acq_noslip: got %0d slips want 0", slip_cnt - s0);
        else n_pass++;
    endtask

    task automatic test_slip();
        int s0;
        test_reset();
        s0 = slip_cnt;
        for (int b = 0; b < 10; b++) begin
            send_block((b == 9) ? 2'b00 : ((b % 2 == 1) ? 2'b10 : 2'b01), rnd64());
            if (b == 8) begin
                n_checks++;
                if (slip_at_hdr !== 1'b0) $display("FAIL slip_early: got slip=%b want 0", slip_at_hdr);
                else n_pass++;
            end
        end
        n_checks++;
        if (slip_at_hdr !== 1'b1) $display("FAIL slip_pulse: got slip=%b want 1", slip_at_hdr);
        else n_pass++;
        n_checks++;
        if (o_gearbox_slip !== 1'b0) $display("FAIL slip_width: got slip=%b want 0", o_gearbox_slip);
        else n_pass++;
        // Wait window: invalid headers sprinkled in, including the last ignored one.
        for (int b = 0; b < 32; b++) begin
            send_block((b % 3 == 1) ? 2'b11 : 2'b01, rnd64());
        end
        n_checks++;
        if (slip_cnt - s0 !== 1) $display("FAIL slip_wait: got %0d slips want 1", slip_cnt - s0);
        else n_pass++;
        for (int b = 0; b < 64; b++) begin
            send_block((b % 2 == 1) ? 2'b01 : 2'b10, rnd64());
            if (b == 62) begin
                n_checks++;
                if (lock_at_hdr !== 1'b0) $display("FAIL relock_early: got lock=%b want 0", lock_at_hdr);
                else n_pass++;
            end
        end
        n_checks++;
        if (lock_at_hdr !== 1'b1) $display("FAIL relock: got lock=%b want 1", lock_at_hdr);
        else n_pass++;
        n_checks++;
        if (slip_cnt - s0 !== 1) $display("FAIL relock_slips: got %0d want 1", slip_cnt - s0);
        else n_pass++;
    endtask

    task automatic test_invalid_threshold();
        int   s0;
        logic held;
        s0   = slip_cnt;
        held = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send_block(((i % 4 == 1) && (i < 60)) ? 2'b11 : 2'b01, rnd64());
            if (lock_at_hdr !== 1'b1) held = 1'b0;
        end
        n_checks++;
        if (held !== 1'b1 || slip_cnt != s0)
            $display("FAIL inv15_hold: got held=%b slips=%0d want held=1 slips=0", held, slip_cnt - s0);
        else n_pass++;
        for (int i = 0; i <= 30; i++) begin
            send_block((i % 2 == 0) ? 2'b00 : 2'b10, rnd64());
            if (i == 28) begin
                n_checks++;
                if ({lock_at_hdr, slip_at_hdr} !== 2'b10)
                    $display("FAIL inv15_next: got lock=%b slip=%b want 1 0", lock_at_hdr, slip_at_hdr);
                else n_pass++;
            end
        end
        n_checks++;
        if ({lock_at_hdr, slip_at_hdr} !== 2'b01)
            $display("FAIL inv16_drop: got lock=%b slip=%b want 0 1", lock_at_hdr, slip_at_hdr);
        else n_pass++;
        n_checks++;
        if ({o_block_lock, o_gearbox_slip} !== 2'b00 || slip_cnt - s0 !== 1)
            $display("FAIL inv16_after: got lock=%b slip=%b n=%0d want 0 0 1", o_block_lock,
                     o_gearbox_slip, slip_cnt - s0);
        else n_pass++;
    endtask

    task automatic test_descramble_idle();
        logic [63:0] r;
        test_reset();
        r     = rnd64();
        seed4 = r[57:0];
        sc    = seed4;
        for (int b = 0; b < 8; b++) begin
            send_block(2'b10, 64'h0000_0000_0000_001E);
            t4_out[2*b]   = out_w0;
            t4_out[2*b+1] = out_w1;
            if (b >= 2) begin
                n_checks++;
                if (out_w0 !== 32'h0000_001E || out_w1 !== 32'h0 || o_rx_hdr !== 2'b10)
                    $display("FAIL idle_words: got w0=%h w1=%h hdr=%b want 0000001e 00000000 10",
                             out_w0, out_w1, o_rx_hdr);
                else n_pass++;
            end
        end
    endtask

    task automatic test_gaps();
        int s0;
        test_reset();
        sc = seed4;
        s0 = slip_cnt;
        for (int b = 0; b < 64; b++) begin
            if (b == 5) begin
                put_word(32'h0000_001E, 1'b1, 1'b1, 2'b10);
                out_w0 = o_rx_data;
                put_word(32'h0, 1'b0, 1'b0, 2'b10);
                put_word(32'h0, 1'b0, 1'b1, 2'b00);
                n_checks++;
                if ({o_rx_hdr_valid, o_rx_data_valid} !== 2'b00)
                    $display("FAIL stray_hdr: got hv=%b dv=%b want 0 0", o_rx_hdr_valid, o_rx_data_valid);
                else n_pass++;
                put_word(32'h0, 1'b0, 1'b0, 2'b10);
                put_word(32'h0, 1'b1, 1'b0, 2'b10);
                out_w1 = o_rx_data;
            end else begin
                send_block(2'b10, 64'h0000_0000_0000_001E);
            end
            if (b < 8) begin
                n_checks++;
                if (out_w0 !== t4_out[2*b] || out_w1 !== t4_out[2*b+1])
                    $display("FAIL gap_vs_gapless: blk %0d got %h %h want %h %h", b, out_w0, out_w1,
                             t4_out[2*b], t4_out[2*b+1]);
                else n_pass++;
            end
            if (b == 62) begin
                n_checks++;
                if (lock_at_hdr !== 1'b0) $display("FAIL gap_lock_early: got lock=%b want 0", lock_at_hdr);
                else n_pass++;
            end
        end
        n_checks++;
        if (lock_at_hdr !== 1'b1 || slip_cnt - s0 !== 0)
            $display("FAIL gap_lock: got lock=%b slips=%0d want 1 0", lock_at_hdr, slip_cnt - s0);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int s0;
        test_reset();
        for (int b = 0; b < 64; b++) send_block(2'b01, rnd64());
        s0 = slip_cnt;
        put_word(32'h1234_5678, 1'b1, 1'b1, 2'b01);
        n_checks++;
        if (o_block_lock !== 1'b1) $display("FAIL ar_prelock: got lock=%b want 1", o_block_lock);
        else n_pass++;
        #2;
        i_reset_n = 1'b0;
        #1;
        n_checks++;
        if ({o_rx_data, o_rx_data_valid, o_rx_hdr, o_rx_hdr_valid, o_block_lock,
             o_gearbox_slip} !== 38'h0)
            $display("FAIL ar_outputs: got %h_%b_%b_%b_%b_%b want all 0", o_rx_data, o_rx_data_valid,
                     o_rx_hdr, o_rx_hdr_valid, o_block_lock, o_gearbox_slip);
        else n_pass++;
        sb_q.delete();
        idle(2);
        words_since_rst = 0;
        i_reset_n = 1'b1;
        idle(2);
        for (int b = 0; b < 64; b++) begin
            send_block((b % 2 == 1) ? 2'b10 : 2'b01, rnd64());
            if (b == 62) begin
                n_checks++;
                if (lock_at_hdr !== 1'b0) $display("FAIL ar_lock_early: got lock=%b want 0", lock_at_hdr);
                else n_pass++;
            end
        end
        n_checks++;
        if (lock_at_hdr !== 1'b1 || slip_cnt - s0 !== 0)
            $display("FAIL ar_relock: got lock=%b slips=%0d want 1 0", lock_at_hdr, slip_cnt - s0);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle(2);
        test_lock_acquire();
        test_slip();
        test_invalid_threshold();
        test_descramble_idle();
        test_gaps();
        test_async_reset();
        idle(3);
        n_checks++;
        if (sb_q.size() !== 0) $display("FAIL sb_final: got %0d pending want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_block_sync_descrambler.md
Name: rx_block_sync_descrambler

Overview:
- Receive-path stage between the RX gearbox and the xgmii decoder.
- Runs the 64b/66b block-lock state machine on sync headers and drives a one-cycle slip request back to the gearbox until it achieves alignment.
- Self-synchronously descrambles the 64-bit payload, delivered as two 32-bit words per block.
- Produces the data/header/lock interface the decoder consumes.

Parameters:
DATA_WIDTH, 32, payload word width (fixed 32; two words per 66b block)
HDR_WIDTH, 2, sync header width
SH_CNT_MAX, 64, headers per test window
SH_INVLD_MAX, 16, invalid headers in a window that drop lock
SLIP_WAIT, 32, header events ignored after a slip while the gearbox realigns

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_rx_data  in  DATA_WIDTH  scrambled payload word from gearbox
i_rx_data_valid  in  1  word valid
i_rx_hdr  in  HDR_WIDTH  sync header, meaningful with first word of block
i_rx_hdr_valid  in  1  header valid (first word of each block only)
o_rx_data  out  DATA_WIDTH  descrambled word
o_rx_data_valid  out  1  descrambled word valid
o_rx_hdr  out  HDR_WIDTH  registered header
o_rx_hdr_valid  out  1  registered header valid
o_block_lock  out  1  block lock status
o_gearbox_slip  out  1  one-cycle slip request to gearbox

Behaviour:
- Clock/reset: one clock, i_clk. Reset is asynchronous and active-low, on i_reset_n. While reset is asserted, every output is 0, the descrambler state is 0, all counters are 0, and the FSM is in LOCK_INIT.
- Header events: a header event is i_rx_hdr_valid & i_rx_data_valid. i_rx_hdr_valid without i_rx_data_valid is ignored.
- Valid header: a header is valid when it equals 2'b01 or 2'b10. 2'b00 and 2'b11 are invalid.
- Descrambler polynomial: x^58 + x^39 + 1, with a 58-bit state s.
  - Bits are processed LSB first within each word.
  - out[i] = in[i] ^ s[38] ^ s[57], then s shifts by one with the received (scrambled) bit in[i] entering s[0].
  - Implement all 32 bits as one combinational unroll per word.
- State update: the state updates only when i_rx_data_valid=1 and holds otherwise. The header is never scrambled or descrambled. The descrambler runs regardless of lock state.
- Output latency: 1 cycle.
  - o_rx_data, o_rx_data_valid, o_rx_hdr and o_rx_hdr_valid register the descrambled word, i_rx_data_valid, i_rx_hdr and header event respectively.
  - o_rx_data and o_rx_hdr hold their last value when valid is low.
- FSM states: LOCK_INIT, TEST_SH, SLIP, SLIP_WAIT.
  - LOCK_INIT: clear sh_cnt and sh_invld_cnt, then go to TEST_SH next cycle.
  - TEST_SH, on each header event:
    - Increment sh_cnt. Increment sh_invld_cnt if the header is invalid.
    - If not locked and the header is invalid: go to SLIP.
    - If locked and sh_invld_cnt reaches SH_INVLD_MAX: clear o_block_lock and go to SLIP.
    - Else if sh_cnt reaches SH_CNT_MAX: set o_block_lock if sh_invld_cnt==0, clear both counters, and stay in TEST_SH.
    - If the window-end event and the invalid-threshold event occur on the same header, the invalid-threshold path (SLIP) wins.
  - SLIP:
    - Assert o_gearbox_slip for exactly one cycle.
    - Clear counters.
    - Load the wait counter with SLIP_WAIT and go to SLIP_WAIT.
  - SLIP_WAIT: decrement on each header event. At 0, go to TEST_SH. Headers seen here are not counted.
- Lock outputs: o_block_lock and o_gearbox_slip are registered and change the cycle after the deciding header event. o_gearbox_slip is never asserted on two consecutive cycles.
- Counter widths: sh_cnt is 7 bits, sh_invld_cnt is 5 bits, and the wait counter is clog2(SLIP_WAIT+1) bits. The counters saturate logic-wise because they are cleared before they can wrap.
- Output gating: o_rx_data_valid is not gated by lock. The decoder gates with o_block_lock.
- Reset mid-operation: lock is dropped immediately (asynchronously), and no slip is issued.

Test Plan:
1. Reset, then 64 blocks with alternating headers 01/10 and arbitrary data -> o_block_lock=1 one cycle after the 64th header event, and o_gearbox_slip never asserted.
2. Unlocked, header 2'b00 on block 10 -> o_gearbox_slip high for exactly 1 cycle. The next 32 header events are ignored, even if invalid. Lock then rises after 64 further valid headers.
3. Locked, with 15 invalid headers spread in one 64-header window -> lock stays 1 and the window resets. Then 16 invalid headers within one window -> o_block_lock=0 and one slip pulse, both the cycle after the 16th invalid header.
4. Feed the reference scrambler output of idle blocks (payload 0x0000_0000_0000_001E, header 10) from a random seed -> from the third block onward, o_rx_data reads word0=0x0000001E then word1=0x00000000. o_rx_hdr=10 unchanged. 1-cycle latency.
5. Repeat test 4 with i_rx_data_valid deasserted for 3 cycles mid-block and i_rx_hdr_valid pulsed without data_valid -> output data is identical to the gapless run, and the stray header is not counted.
6. Assert i_reset_n low asynchronously mid-lock (between clock edges) -> all outputs 0 immediately. After release, lock is regained only after 64 valid headers.
